instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Boot-time writer for the single-cycle core's instruction memory. It receives a big-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive word addresses starting at 0. It holds the core in reset until the whole program image is written, then releases it. It sits between the external boot link and the instruction memory write port, and drives the core's `rst_n`.

## Interface
Parameters:
- `MAX_WORDS`, default 256: instruction memory capacity in words; must be a power of two, at most 65536.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `byte_in`, input, 8: stream byte.
- `byte_valid`, input, 1: `byte_in` is valid.
- `byte_ready`, output, 1: loader accepts a byte this cycle.
- `reload`, input, 1: synchronous request to reload; honoured only in DONE or ERROR.
- `imem_write_en`, output, 1: one-cycle instruction memory write strobe.
- `imem_write_addr`, output, 32: byte address of the write (word index << 2).
- `imem_write_data`, output, 32: instruction word.
- `core_rst_n`, output, 1: active-low reset to the processor core.
- `load_done`, output, 1: image loaded; equal to `core_rst_n`.
- `load_err`, output, 1: header word count exceeded `MAX_WORDS`.

## Operation
- A byte transfer occurs on an edge where `byte_valid && byte_ready` is true. Bytes presented without `byte_ready` are not consumed.
- Stream format:
  - First 2 bytes: 16-bit word count N, high byte first.
  - Then N words of 4 bytes each, most significant byte first.
- States:
  - HDR_HI: receives the high count byte. Goes to HDR_LO on transfer.
  - HDR_LO: receives the low count byte.
    - N = 0: go to DONE; no writes occur.
    - N > `MAX_WORDS`: go to ERROR.
    - Otherwise: go to DATA.
  - DATA: shifts bytes into a 24-bit accumulator while a 2-bit byte counter tracks position.
    - On the 4th byte, `imem_write_data <= {acc, byte_in}` and `imem_write_addr <= word_idx << 2`, and `imem_write_en` pulses high the next cycle. `word_idx` then increments.
    - On the 4th byte of word N-1, go to DONE.
  - DONE: `byte_ready` = 0. `core_rst_n` goes high one edge after entering DONE. On `reload`: go to HDR_HI, with `core_rst_n` low and `load_done` low at the next edge, and all counters cleared.
  - ERROR: `byte_ready` = 0, `load_err` = 1, `core_rst_n` held low. `reload` returns to HDR_HI and clears `load_err`.
- `byte_ready` is 1 in HDR_HI, HDR_LO and DATA, including the cycle in which `imem_write_en` is high. Back-to-back bytes are accepted every cycle.
- `reload` is ignored in HDR_HI, HDR_LO and DATA.
- The loader never writes at or beyond `MAX_WORDS`*4.

## Timing
- Reset values:
  - State HDR_HI.
  - `byte_ready` = 1.
  - `imem_write_en` = 0.
  - `imem_write_addr` = 0.
  - `imem_write_data` = 0.
  - `core_rst_n` = 0, `load_done` = 0, `load_err` = 0.
- Write latency: `imem_write_en` is high for exactly the cycle after the edge that accepts the 4th byte. Address and data are stable during that cycle and hold their values afterwards.
- Core release: if the last byte is accepted at edge T, `imem_write_en` is high in cycle T..T+1 and `core_rst_n` rises at edge T+1. The core's first fetch therefore sees the final word already written, because the memory write occurs at edge T+1.
- N = 0: `core_rst_n` rises two edges after the low count byte is accepted.
- Mid-operation `rst_n` assertion: the loader returns immediately to reset values, drops any partial word, and holds the core in reset.
- All outputs are registered; there are no combinational paths from inputs to outputs. The one exception is `byte_ready`, which is decoded from state only.

## Structure
- Shared package/include `loader_defs`:
  - State encodings (HDR_HI, HDR_LO, DATA, DONE, ERROR).
  - Header width constant (16).
  - Bytes-per-word constant (4).
- Sub-module `word_assembler`:
  - Contains the 24-bit accumulator and 2-bit byte counter.
  - Takes `clk`, `rst_n`, `clear`, `byte_in` and `accept`.
  - Produces a one-cycle `word_valid` and a 32-bit `word`.
  - The top level contains the FSM, the `word_idx` counter and the reset release.

## Test plan
- Basic load: stream 00 02, DE AD BE EF, 12 34 56 78 with continuous valid. Required response:
  - Write addr 0x0 data 0xDEADBEEF.
  - Write addr 0x4 data 0x12345678.
  - `core_rst_n` rises one edge after the second write pulse.
  - `byte_ready` drops in DONE.
- Count 0: stream 00 00. Required response: no `imem_write_en`, `load_done` = 1 two edges later.
- Overflow: with `MAX_WORDS` = 256, stream 01 01. Required response:
  - `load_err` = 1, `byte_ready` = 0, `core_rst_n` stays 0.
  - Then `reload` pulse: state returns to HDR_HI and `load_err` = 0.
- Gapped handshake: `byte_valid` toggles randomly. Required response: written words are identical to the basic load; bytes held while `byte_ready` = 0 are not consumed.
- Reset mid-word: assert `rst_n` low after 2 data bytes, then stream 00 01 AA BB CC DD. Required response: a single write of addr 0x0 data 0xAABBCCDD.
- Reload after DONE: pulse `reload`, then stream 00 01 01 02 03 04. Required response:
  - `core_rst_n` low at the next edge.
  - Write addr 0x0 data 0x01020304.
  - `core_rst_n` then rises again.

Source files
------------

// File: rtl/loader_defs.sv
// Shared definitions for the instruction memory boot loader.
// State encodings and stream framing constants.
package loader_defs;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  localparam int HDR_W          = 16;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs big-endian stream bytes into 32-bit words.
// Emits a registered one-cycle word_valid with the finished word.
module word_assembler
  import loader_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        accept,
  output logic        last,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_POS = 2'(BYTES_PER_WORD - 1);

  logic [23:0] acc_q;
  logic [1:0]  cnt_q;
  logic        vld_q;
  logic [31:0] word_q;

  assign last       = (cnt_q == LAST_POS);
  assign word_valid = vld_q;
  assign word       = word_q;

  // Shift bytes in; the fourth byte completes and publishes a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= accept && last;
      if (accept) begin
        if (last) begin
          word_q <= {acc_q, byte_in};
          acc_q  <= '0;
          cnt_q  <= '0;
        end else begin
          acc_q <= {acc_q[15:0], byte_in};
          cnt_q <= cnt_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: writes a counted word image into instruction memory,
// holding the core in reset until the image is complete.
module instr_mem_loader
  import loader_defs::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        reload,
  output logic        imem_write_en,
  output logic [31:0] imem_write_addr,
  output logic [31:0] imem_write_data,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_e           state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic [HDR_W-1:0] n_q, n_d;
  logic [15:0]      idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;
  logic             rel_q, rel_d;
  logic             err_q, err_d;
  logic             clr;
  logic             xfer;
  logic             asm_accept;
  logic             asm_last;
  logic             asm_valid;
  logic [31:0]      asm_word;
  logic [15:0]      hdr_n;

  assign byte_ready = (state_q == S_HDR_HI) ||
                      (state_q == S_HDR_LO) ||
                      (state_q == S_DATA);
  assign xfer       = byte_valid && byte_ready;
  assign hdr_n      = {hi_q, byte_in};
  assign asm_accept = (state_q == S_DATA) && byte_valid;

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clr),
    .byte_in    (byte_in),
    .accept     (asm_accept),
    .last       (asm_last),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  assign imem_write_en   = asm_valid;
  assign imem_write_addr = addr_q;
  assign imem_write_data = asm_word;
  assign core_rst_n      = rel_q;
  assign load_done       = rel_q;
  assign load_err        = err_q;

  // Next-state, header capture, word index and release decisions.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    n_d     = n_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    clr     = 1'b0;
    unique case (state_q)
      S_HDR_HI: begin
        if (xfer) begin
          hi_d    = byte_in;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer) begin
          n_d = hdr_n;
          if (hdr_n == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, hdr_n} > MAX_W) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer && asm_last) begin
          addr_d = {14'd0, idx_q, 2'b00};
          idx_d  = idx_q + 16'd1;
          if (idx_q == n_q - 16'd1) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          state_d = S_HDR_HI;
          clr     = 1'b1;
          hi_d    = '0;
          n_d     = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_HDR_HI;
      end
    endcase
    rel_d = (state_q == S_DONE) && !reload;
    err_d = (state_d == S_ERROR);
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR_HI;
      hi_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      rel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised bench for instr_mem_loader.
// Writes are compared against a stream-level reference model.
module tb_instr_mem_loader;

  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        reload;
  logic        imem_write_en;
  logic [31:0] imem_write_addr;
  logic [31:0] imem_write_data;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  instr_mem_loader #(.MAX_WORDS(MAXW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .reload          (reload),
    .imem_write_en   (imem_write_en),
    .imem_write_addr (imem_write_addr),
    .imem_write_data (imem_write_data),
    .core_rst_n      (core_rst_n),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t got[$];
  wr_t exp_q[$];
  bit  exp_err;
  bit  exp_done;
  int  n_checks = 0;
  int  n_fail   = 0;

  always @(negedge clk) begin
    if (rst_n && imem_write_en) begin
      wr_t w;
      w.addr = imem_write_addr;
      w.data = imem_write_data;
      got.push_back(w);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] b[$]);
    int n;
    exp_q.delete();
    n = int'(b[0]) * 256 + int'(b[1]);
    exp_err  = (n > MAXW);
    exp_done = !exp_err;
    if (!exp_err) begin
      for (int w = 0; w < n; w++) begin
        wr_t e;
        e.addr = 32'(w * 4);
        e.data = {b[2+4*w], b[3+4*w], b[4+4*w], b[5+4*w]};
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic send(input logic [7:0] b[$], input bit gapped);
    int  i = 0;
    int  budget = 0;
    bit  acc;
    while (i < b.size()) begin
      @(negedge clk);
      byte_in    = b[i];
      byte_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      acc        = byte_valid && byte_ready;
      @(posedge clk);
      if (acc) i++;
      budget++;
      if (budget > 2000) begin
        check("send_timeout", 32'(i), 32'(b.size()));
        break;
      end
    end
    #1 byte_valid = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
  endtask

  task automatic compare_writes(input string name);
    check({name, "_nwr"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      check({name, "_addr"}, got[k].addr, exp_q[k].addr);
      check({name, "_data"}, got[k].data, exp_q[k].data);
    end
  endtask

  task automatic run_prog(input string name,
                          input logic [7:0] b[$],
                          input bit gapped);
    got.delete();
    model(b);
    send(b, gapped);
    repeat (3) @(negedge clk);
    compare_writes(name);
    check({name, "_done"}, 32'(load_done), 32'(exp_done));
    check({name, "_err"}, 32'(load_err), 32'(exp_err));
    check({name, "_core"}, 32'(core_rst_n), 32'(exp_done));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_rdy"}, 32'(byte_ready), 32'd1);
    check({name, "_we"}, 32'(imem_write_en), 32'd0);
    check({name, "_addr"}, imem_write_addr, 32'd0);
    check({name, "_data"}, imem_write_data, 32'd0);
    check({name, "_core"}, 32'(core_rst_n), 32'd0);
    check({name, "_done"}, 32'(load_done), 32'd0);
    check({name, "_err"}, 32'(load_err), 32'd0);
  endtask

  logic [7:0] basic[$];
  logic [7:0] bs[$];

  initial begin
    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    reload     = 1'b0;
    basic = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h12, 8'h34, 8'h56, 8'h78};
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // basic continuous load with release timing
    got.delete();
    model(basic);
    send(basic, 1'b0);
    @(negedge clk);
    check("basic_we_last", 32'(imem_write_en), 32'd1);
    check("basic_core_hold", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    check("basic_core_rel", 32'(core_rst_n), 32'd1);
    check("basic_done", 32'(load_done), 32'd1);
    check("basic_we_off", 32'(imem_write_en), 32'd0);
    check("basic_rdy_done", 32'(byte_ready), 32'd0);
    check("basic_addr_hold", imem_write_addr, 32'h4);
    check("basic_data_hold", imem_write_data, 32'h12345678);
    compare_writes("basic");

    // bytes offered in DONE are not consumed
    got.delete();
    @(negedge clk);
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    check("done_ignore_nwr", 32'(got.size()), 32'd0);
    check("done_ignore_core", 32'(core_rst_n), 32'd1);

    // reload after DONE
    do_reload();
    @(negedge clk);
    check("reload_core", 32'(core_rst_n), 32'd0);
    check("reload_done", 32'(load_done), 32'd0);
    check("reload_rdy", 32'(byte_ready), 32'd1);
    bs = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    run_prog("reload", bs, 1'b0);

    // zero-length image
    do_reload();
    got.delete();
    bs = '{8'h00, 8'h00};
    send(bs, 1'b0);
    @(negedge clk);
    check("zero_core_hold", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    check("zero_done", 32'(load_done), 32'd1);
    check("zero_rdy", 32'(byte_ready), 32'd0);
    check("zero_nwr", 32'(got.size()), 32'd0);

    // header overflow
    do_reload();
    bs = '{8'h01, 8'h01};
    send(bs, 1'b0);
    @(negedge clk);
    check("ovf_err", 32'(load_err), 32'd1);
    check("ovf_rdy", 32'(byte_ready), 32'd0);
    check("ovf_core", 32'(core_rst_n), 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_core_held", 32'(core_rst_n), 32'd0);
    do_reload();
    @(negedge clk);
    check("ovf_clr_err", 32'(load_err), 32'd0);
    check("ovf_clr_rdy", 32'(byte_ready), 32'd1);

    // gapped handshake gives the same image
    run_prog("gapped", basic, 1'b1);

    // reset in the middle of a word
    do_reload();
    bs = '{8'h00, 8'h02, 8'h11, 8'h22};
    got.delete();
    send(bs, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst_nwr", 32'(got.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bs = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_prog("midrst_load", bs, 1'b0);

    // random images, some oversized
    for (int r = 0; r < 8; r++) begin
      int n;
      do_reload();
      n = (r == 5) ? 257 + int'($urandom_range(0, 200))
                   : int'($urandom_range(1, 6));
      bs.delete();
      bs.push_back(8'(n >> 8));
      bs.push_back(8'(n));
      if (n <= MAXW) begin
        for (int k = 0; k < 4 * n; k++) begin
          bs.push_back(8'($urandom));
        end
      end
      run_prog("rand", bs, 1'(r % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
